// File: rtl/cond_ctrl_pipe.sv
// Control-word pipeline behind Decode: ARM condition gating in Execute, NZCV register,
// per-stage stall/flush with valid tracking, and a conservative pending-PC-write flag.
module cond_ctrl_pipe #(
    parameter int CW   = 8,
    parameter int NSTG = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                d_valid,
    input  logic [CW-1:0]       d_ctrl,
    input  logic [3:0]          d_cond,
    input  logic [1:0]          d_flagwr,
    input  logic [NSTG-1:0]     stall,
    input  logic [NSTG-1:0]     flush,
    input  logic [3:0]          alu_flags,
    output logic [NSTG*CW-1:0]  stg_ctrl,
    output logic [NSTG-1:0]     stg_valid,
    output logic [CW-1:0]       e_ctrl_gated,
    output logic [3:0]          flags,
    output logic                cond_pass_e,
    output logic                branch_taken_e,
    output logic                pc_wr_pending
);

    logic [NSTG-1:0]          sv_q, sv_d;
    logic [NSTG-1:0][CW-1:0]  sc_q, sc_d;
    logic [3:0]               cond_q, cond_d;
    logic [1:0]               fw_q, fw_d;
    logic [3:0]               flags_q, flags_d;
    logic                     cond_true;

    always_comb begin
        cond_true = 1'b0;
        unique case (cond_q)
            4'h0: cond_true = flags_q[2];
            4'h1: cond_true = !flags_q[2];
            4'h2: cond_true = flags_q[1];
            4'h3: cond_true = !flags_q[1];
            4'h4: cond_true = flags_q[3];
            4'h5: cond_true = !flags_q[3];
            4'h6: cond_true = flags_q[0];
            4'h7: cond_true = !flags_q[0];
            4'h8: cond_true = flags_q[1] & !flags_q[2];
            4'h9: cond_true = !flags_q[1] | flags_q[2];
            4'hA: cond_true = (flags_q[3] == flags_q[0]);
            4'hB: cond_true = (flags_q[3] != flags_q[0]);
            4'hC: cond_true = !flags_q[2] & (flags_q[3] == flags_q[0]);
            4'hD: cond_true = flags_q[2] | (flags_q[3] != flags_q[0]);
            4'hE: cond_true = 1'b1;
            4'hF: cond_true = 1'b0;
        endcase
    end

    always_comb begin
        cond_pass_e       = sv_q[0] & cond_true;
        e_ctrl_gated      = sc_q[0];
        e_ctrl_gated[3:0] = sc_q[0][3:0] & {4{cond_pass_e}};
        branch_taken_e    = cond_pass_e & sc_q[0][3];
    end

    always_comb begin
        sv_d    = sv_q;
        sc_d    = sc_q;
        cond_d  = cond_q;
        fw_d    = fw_q;
        flags_d = flags_q;
        if (flush[0]) begin
            sv_d[0] = 1'b0;
            sc_d[0] = '0;
            cond_d  = '0;
            fw_d    = '0;
        end else if (!stall[0]) begin
            sv_d[0] = d_valid;
            sc_d[0] = d_valid ? d_ctrl : '0;
            cond_d  = d_valid ? d_cond : 4'h0;
            fw_d    = d_valid ? d_flagwr : 2'b00;
        end
        // A stage whose upstream is holding must not duplicate that content downstream.
        for (int k = 1; k < NSTG; k++) begin
            if (flush[k]) begin
                sv_d[k] = 1'b0;
                sc_d[k] = '0;
            end else if (stall[k]) begin
                sv_d[k] = sv_q[k];
            end else if (stall[k-1]) begin
                sv_d[k] = 1'b0;
                sc_d[k] = '0;
            end else begin
                sv_d[k] = sv_q[k-1];
                sc_d[k] = (k == 1) ? e_ctrl_gated : sc_q[k-1];
            end
        end
        // Flags commit only when the Execute instruction actually moves on to stage 1.
        if (cond_pass_e && !stall[0] && !flush[1]) begin
            if (fw_q[1]) flags_d[3:2] = alu_flags[3:2];
            if (fw_q[0]) flags_d[1:0] = alu_flags[1:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sv_q    <= '0;
            sc_q    <= '0;
            cond_q  <= '0;
            fw_q    <= '0;
            flags_q <= '0;
        end else begin
            sv_q    <= sv_d;
            sc_q    <= sc_d;
            cond_q  <= cond_d;
            fw_q    <= fw_d;
            flags_q <= flags_d;
        end
    end

    always_comb begin
        pc_wr_pending = (d_valid & d_ctrl[0]) | (sv_q[0] & sc_q[0][0]);
        for (int k = 1; k < NSTG; k++)
            pc_wr_pending = pc_wr_pending | sc_q[k][0];
    end

    assign stg_ctrl  = sc_q;
    assign stg_valid = sv_q;
    assign flags     = flags_q;

endmodule
